uart_rx_deser_gen: RTL

Parametrised successor to the UART Rx deserializer. It assembles a runtime-configurable number of sampled data bits into a parallel word, LSB-first or MSB-first. It owns its bit counter and computes frame parity on the fly. A one-cycle valid strobe marks each completed word. It sits between the Rx sampler/FSM and the parity/stop checkers in the UART_Rx datapath.

---
 rtl/uart_rx_pkg.sv | 31 +++
 rtl/uart_rx_deser_gen_if.sv | 31 +++
 rtl/uart_rx_par_acc.sv | 36 +++
 rtl/uart_rx_deser_gen.sv | 132 +++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and constants for the UART Rx deserializer.
//   state_e       - deserializer FSM states
//   PAR_EVEN/ODD  - encodings of cfg_par_type
//   MIN_DATA_LEN  - shortest legal frame
//   clamp_len()   - maps a requested data length onto the legal range
package uart_rx_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StDone  = 2'd2
   } state_e;

   localparam bit          PAR_EVEN     = 1'b0;
   localparam bit          PAR_ODD      = 1'b1;
   localparam int unsigned MIN_DATA_LEN = 5;

   // 0 or anything wider than the datapath means "full width"; short
   // requests are raised to the minimum frame length.
   function automatic int unsigned clamp_len(input int unsigned len,
                                             input int unsigned max_len);
      if (len == 0 || len > max_len) begin
         return max_len;
      end
      if (len < MIN_DATA_LEN) begin
         return MIN_DATA_LEN;
      end
      return len;
   endfunction

endpackage

// File: rtl/uart_rx_deser_gen_if.sv
// uart_rx_deser_gen_if: bundle between the Rx FSM/sampler and the deserializer.
//   frame_start/frame_abort/deser_en/sampled_bit/cfg_* : FSM -> deserializer
//   P_DATA/P_DATA_VLD/par_bit/busy                      : deserializer -> checkers
// master drives the control side, slave is the deserializer.
interface uart_rx_deser_gen_if #(
   parameter int unsigned DATA_WIDTH = 8
);
   localparam int unsigned LEN_W = $clog2(DATA_WIDTH + 1);

   logic                  frame_start;
   logic                  frame_abort;
   logic                  deser_en;
   logic                  sampled_bit;
   logic [LEN_W-1:0]      cfg_data_len;
   logic                  cfg_par_type;
   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  P_DATA_VLD;
   logic                  par_bit;
   logic                  busy;

   modport master (
      output frame_start, frame_abort, deser_en, sampled_bit, cfg_data_len, cfg_par_type,
      input  P_DATA, P_DATA_VLD, par_bit, busy
   );

   modport slave (
      input  frame_start, frame_abort, deser_en, sampled_bit, cfg_data_len, cfg_par_type,
      output P_DATA, P_DATA_VLD, par_bit, busy
   );

endinterface

// File: rtl/uart_rx_par_acc.sv
// uart_rx_par_acc: running parity of the data bits of one frame.
//   clk_i, rst_i : clock, synchronous active-high reset
//   clr_i        : start of frame; clears the accumulator and latches type_i
//   en_i, bit_i  : fold bit_i into the accumulator
//   type_i       : parity type (PAR_EVEN/PAR_ODD), sampled on clr_i
//   par_o        : expected parity bit for the bits folded so far
module uart_rx_par_acc
   import uart_rx_pkg::*;
(
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   input  logic bit_i,
   input  logic type_i,
   output logic par_o
);

   logic acc_q;
   logic type_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc_q  <= 1'b0;
         type_q <= PAR_EVEN;
      end else if (clr_i) begin
         acc_q  <= 1'b0;
         type_q <= type_i;
      end else if (en_i) begin
         acc_q  <= acc_q ^ bit_i;
      end
   end

   assign par_o = acc_q ^ (type_q == PAR_ODD);

endmodule

// File: rtl/uart_rx_deser_gen.sv
// uart_rx_deser_gen: assembles 5..DATA_WIDTH sampled bits into a parallel word.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : uart_rx_deser_gen_if.slave
//              inputs  frame_start, frame_abort, deser_en, sampled_bit, cfg_data_len,
//                      cfg_par_type
//              outputs P_DATA (right-aligned word), P_DATA_VLD (1-cycle strobe),
//                      par_bit (expected parity), busy (SHIFT or DONE)
// MSB_FIRST = 0 places the first bit in P_DATA[0]; 1 places it in P_DATA[len-1].
module uart_rx_deser_gen
   import uart_rx_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter bit          MSB_FIRST  = 1'b0
) (
   input  logic               CLK,
   input  logic               RST,
   uart_rx_deser_gen_if.slave bus
);

   localparam int unsigned LEN_W = $clog2(DATA_WIDTH + 1);

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
   logic [DATA_WIDTH-1:0] len_mask;
   logic [LEN_W-1:0]      cnt_q, cnt_d;
   logic [LEN_W-1:0]      len_q, len_d;
   logic                  vld_q, vld_d;
   logic                  par_bit_q, par_bit_d;
   logic                  restart;
   logic                  acc_en;
   logic                  acc_par;

   always_comb begin
      for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
         len_mask[i] = (i < 32'(len_q));
      end
   end

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      cnt_d     = cnt_q;
      len_d     = len_q;
      p_data_d  = p_data_q;
      vld_d     = 1'b0;
      par_bit_d = par_bit_q;
      restart   = 1'b0;
      acc_en    = 1'b0;

      case (state_q)
         StIdle: begin
            restart = bus.frame_start && !bus.frame_abort;
         end
         StShift: begin
            if (bus.frame_abort) begin
               state_d = StIdle;
            end else if (bus.frame_start) begin
               // Restart wins over a coincident data bit, which is dropped.
               restart = 1'b1;
            end else if (bus.deser_en) begin
               if (MSB_FIRST) begin
                  shreg_d = {shreg_q[DATA_WIDTH-2:0], bus.sampled_bit};
               end else begin
                  // Register is cleared at frame start, so OR-ing places the bit.
                  shreg_d = shreg_q | (DATA_WIDTH'(bus.sampled_bit) << cnt_q);
               end
               acc_en = 1'b1;
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q == len_q - 1'b1) begin
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            if (bus.frame_abort) begin
               state_d = StIdle;
            end else begin
               p_data_d  = shreg_q & len_mask;
               vld_d     = 1'b1;
               par_bit_d = acc_par;
               state_d   = StIdle;
               restart   = bus.frame_start;
            end
         end
         default: state_d = StIdle;
      endcase

      if (restart) begin
         shreg_d = '0;
         cnt_d   = '0;
         len_d   = LEN_W'(clamp_len(32'(bus.cfg_data_len), DATA_WIDTH));
         state_d = StShift;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= StIdle;
         shreg_q   <= '0;
         p_data_q  <= '0;
         cnt_q     <= '0;
         len_q     <= '0;
         vld_q     <= 1'b0;
         par_bit_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         p_data_q  <= p_data_d;
         cnt_q     <= cnt_d;
         len_q     <= len_d;
         vld_q     <= vld_d;
         par_bit_q <= par_bit_d;
      end
   end

   uart_rx_par_acc u_par_acc (
      .clk_i  (CLK),
      .rst_i  (RST),
      .clr_i  (restart),
      .en_i   (acc_en),
      .bit_i  (bus.sampled_bit),
      .type_i (bus.cfg_par_type),
      .par_o  (acc_par)
   );

   assign bus.P_DATA     = p_data_q;
   assign bus.P_DATA_VLD = vld_q;
   assign bus.par_bit    = par_bit_q;
   assign bus.busy       = (state_q != StIdle);

endmodule
